// File: rtl/l2_mem_arbiter.sv
// Serialises two L2 ports' miss reads and write-backs (four single-entry slots) onto one
// memory req/ack channel; write-backs win over reads, round-robin by port within a class.
module l2_mem_arbiter #(
  parameter int tag_bits   = 24,
  parameter int index_bits = 7,
  parameter int block_size = 512
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           memory_read_1,
  input  logic                           memory_read_2,
  input  logic                           memory_write_1,
  input  logic                           memory_write_2,
  input  logic [tag_bits-1:0]            tag_1_L2,
  input  logic [tag_bits-1:0]            tag_2_L2,
  input  logic [index_bits-1:0]          index_1_L2,
  input  logic [index_bits-1:0]          index_2_L2,
  input  logic [block_size-1:0]          wb_data_1,
  input  logic [block_size-1:0]          wb_data_2,
  output logic                           busy_1,
  output logic                           busy_2,
  output logic                           overflow_1,
  output logic                           overflow_2,
  output logic                           fill_valid_1,
  output logic                           fill_valid_2,
  output logic [block_size-1:0]          fill_data_1,
  output logic [block_size-1:0]          fill_data_2,
  output logic [tag_bits-1:0]            fill_tag_1,
  output logic [tag_bits-1:0]            fill_tag_2,
  output logic [index_bits-1:0]          fill_index_1,
  output logic [index_bits-1:0]          fill_index_2,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [tag_bits+index_bits-1:0] mem_addr,
  output logic [block_size-1:0]          mem_wdata,
  input  logic                           mem_ack,
  input  logic [block_size-1:0]          mem_rdata
);

  localparam int addr_bits = tag_bits + index_bits;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [1:0]            rd_vld_q, rd_vld_d, wr_vld_q, wr_vld_d;
  logic [tag_bits-1:0]   rd_tag_q [2], rd_tag_d [2], wr_tag_q [2], wr_tag_d [2];
  logic [index_bits-1:0] rd_idx_q [2], rd_idx_d [2], wr_idx_q [2], wr_idx_d [2];
  logic [block_size-1:0] wr_data_q [2], wr_data_d [2];
  logic                  cur_port_q, cur_port_d, cur_we_q, cur_we_d;
  logic                  last_port_q, last_port_d;
  logic [1:0]            ovf_q, ovf_d, fill_vld_q, fill_vld_d;
  logic [block_size-1:0] fill_data_q [2], fill_data_d [2];
  logic [tag_bits-1:0]   fill_tag_q [2], fill_tag_d [2];
  logic [index_bits-1:0] fill_idx_q [2], fill_idx_d [2];
  logic                  mem_we_q, mem_we_d;
  logic [addr_bits-1:0]  mem_addr_q, mem_addr_d;
  logic [block_size-1:0] mem_wdata_q, mem_wdata_d;

  // Only a clean 1 is a request; X or Z strobes from the L2 are ignored.
  logic [1:0]            rd_stb, wr_stb;
  logic [tag_bits-1:0]   tag_in [2];
  logic [index_bits-1:0] idx_in [2];
  logic [block_size-1:0] wb_in [2];

  assign rd_stb    = {memory_read_2 === 1'b1, memory_read_1 === 1'b1};
  assign wr_stb    = {memory_write_2 === 1'b1, memory_write_1 === 1'b1};
  assign tag_in[0] = tag_1_L2;
  assign tag_in[1] = tag_2_L2;
  assign idx_in[0] = index_1_L2;
  assign idx_in[1] = index_2_L2;
  assign wb_in[0]  = wb_data_1;
  assign wb_in[1]  = wb_data_2;

  logic [1:0] cand, retire_rd, retire_wr;
  logic       sel_we, sel_port;

  always_comb begin
    state_d     = state_q;
    rd_vld_d    = rd_vld_q;
    wr_vld_d    = wr_vld_q;
    rd_tag_d    = rd_tag_q;
    wr_tag_d    = wr_tag_q;
    rd_idx_d    = rd_idx_q;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    cur_port_d  = cur_port_q;
    cur_we_d    = cur_we_q;
    last_port_d = last_port_q;
    ovf_d       = 2'b00;
    fill_vld_d  = 2'b00;
    fill_data_d = fill_data_q;
    fill_tag_d  = fill_tag_q;
    fill_idx_d  = fill_idx_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    retire_rd   = 2'b00;
    retire_wr   = 2'b00;
    sel_we      = |wr_vld_q;
    cand        = sel_we ? wr_vld_q : rd_vld_q;
    sel_port    = (cand == 2'b11) ? ~last_port_q : cand[1];

    case (state_q)
      IDLE: begin
        if ((|wr_vld_q) || (|rd_vld_q)) begin
          cur_port_d  = sel_port;
          cur_we_d    = sel_we;
          last_port_d = sel_port;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_we ? {wr_tag_q[sel_port], wr_idx_q[sel_port]}
                               : {rd_tag_q[sel_port], rd_idx_q[sel_port]};
          mem_wdata_d = sel_we ? wr_data_q[sel_port] : '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          if (cur_we_q) begin
            retire_wr[cur_port_q] = 1'b1;
            state_d               = IDLE;
          end else begin
            retire_rd[cur_port_q]   = 1'b1;
            fill_vld_d[cur_port_q]  = 1'b1;
            fill_data_d[cur_port_q] = mem_rdata;
            fill_tag_d[cur_port_q]  = mem_addr_q[addr_bits-1:index_bits];
            fill_idx_d[cur_port_q]  = mem_addr_q[index_bits-1:0];
            state_d                 = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A slot retiring on this edge frees up in time to take a new strobe.
    for (int p = 0; p < 2; p++) begin
      if (retire_rd[p]) rd_vld_d[p] = 1'b0;
      if (retire_wr[p]) wr_vld_d[p] = 1'b0;
      if (rd_stb[p]) begin
        if (rd_vld_q[p] && !retire_rd[p]) begin
          ovf_d[p] = 1'b1;
        end else begin
          rd_vld_d[p] = 1'b1;
          rd_tag_d[p] = tag_in[p];
          rd_idx_d[p] = idx_in[p];
        end
      end
      if (wr_stb[p]) begin
        if (wr_vld_q[p] && !retire_wr[p]) begin
          ovf_d[p] = 1'b1;
        end else begin
          wr_vld_d[p]  = 1'b1;
          wr_tag_d[p]  = tag_in[p];
          wr_idx_d[p]  = idx_in[p];
          wr_data_d[p] = wb_in[p];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      rd_vld_q    <= 2'b00;
      wr_vld_q    <= 2'b00;
      rd_tag_q    <= '{default: '0};
      wr_tag_q    <= '{default: '0};
      rd_idx_q    <= '{default: '0};
      wr_idx_q    <= '{default: '0};
      wr_data_q   <= '{default: '0};
      cur_port_q  <= 1'b0;
      cur_we_q    <= 1'b0;
      last_port_q <= 1'b1;
      ovf_q       <= 2'b00;
      fill_vld_q  <= 2'b00;
      fill_data_q <= '{default: '0};
      fill_tag_q  <= '{default: '0};
      fill_idx_q  <= '{default: '0};
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_vld_q    <= rd_vld_d;
      wr_vld_q    <= wr_vld_d;
      rd_tag_q    <= rd_tag_d;
      wr_tag_q    <= wr_tag_d;
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
      cur_port_q  <= cur_port_d;
      cur_we_q    <= cur_we_d;
      last_port_q <= last_port_d;
      ovf_q       <= ovf_d;
      fill_vld_q  <= fill_vld_d;
      fill_data_q <= fill_data_d;
      fill_tag_q  <= fill_tag_d;
      fill_idx_q  <= fill_idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy_1       = rd_vld_q[0] | wr_vld_q[0];
  assign busy_2       = rd_vld_q[1] | wr_vld_q[1];
  assign overflow_1   = ovf_q[0];
  assign overflow_2   = ovf_q[1];
  assign fill_valid_1 = fill_vld_q[0];
  assign fill_valid_2 = fill_vld_q[1];
  assign fill_data_1  = fill_data_q[0];
  assign fill_data_2  = fill_data_q[1];
  assign fill_tag_1   = fill_tag_q[0];
  assign fill_tag_2   = fill_tag_q[1];
  assign fill_index_1 = fill_idx_q[0];
  assign fill_index_2 = fill_idx_q[1];
  assign mem_req      = (state_q == ISSUE);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Bench for l2_mem_arbiter: directed vector table, hand sequences, and a random run
// scored against a transaction-level model of the arbitration and timing rules.
module tb_l2_mem_arbiter;
  localparam int TB = 24, IB = 7, BS = 512, AB = 31;

  logic          CLK = 1'b0, RST = 1'b0;
  logic          memory_read_1, memory_read_2, memory_write_1, memory_write_2;
  logic [TB-1:0] tag_1_L2, tag_2_L2;
  logic [IB-1:0] index_1_L2, index_2_L2;
  logic [BS-1:0] wb_data_1, wb_data_2;
  logic          busy_1, busy_2, overflow_1, overflow_2, fill_valid_1, fill_valid_2;
  logic [BS-1:0] fill_data_1, fill_data_2;
  logic [TB-1:0] fill_tag_1, fill_tag_2;
  logic [IB-1:0] fill_index_1, fill_index_2;
  logic          mem_req, mem_we, mem_ack;
  logic [AB-1:0] mem_addr;
  logic [BS-1:0] mem_wdata, mem_rdata;

  always #5 CLK = ~CLK;

  l2_mem_arbiter #(.tag_bits(TB), .index_bits(IB), .block_size(BS)) dut (
    .CLK(CLK), .RST(RST),
    .memory_read_1(memory_read_1), .memory_read_2(memory_read_2),
    .memory_write_1(memory_write_1), .memory_write_2(memory_write_2),
    .tag_1_L2(tag_1_L2), .tag_2_L2(tag_2_L2),
    .index_1_L2(index_1_L2), .index_2_L2(index_2_L2),
    .wb_data_1(wb_data_1), .wb_data_2(wb_data_2),
    .busy_1(busy_1), .busy_2(busy_2), .overflow_1(overflow_1), .overflow_2(overflow_2),
    .fill_valid_1(fill_valid_1), .fill_valid_2(fill_valid_2),
    .fill_data_1(fill_data_1), .fill_data_2(fill_data_2),
    .fill_tag_1(fill_tag_1), .fill_tag_2(fill_tag_2),
    .fill_index_1(fill_index_1), .fill_index_2(fill_index_2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    memory_read_1 = 1'b0; memory_read_2 = 1'b0;
    memory_write_1 = 1'b0; memory_write_2 = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic check_zero(input string n);
    check({n, "_ctl"}, BS'({busy_1, busy_2, overflow_1, overflow_2,
                            fill_valid_1, fill_valid_2, mem_req, mem_we}), '0);
    check({n, "_addr"}, BS'(mem_addr), '0);
    check({n, "_wdata"}, mem_wdata, '0);
    check({n, "_fdata"}, fill_data_1 | fill_data_2, '0);
    check({n, "_ftagidx"}, BS'({fill_tag_1, fill_tag_2, fill_index_1, fill_index_2}), '0);
  endtask

  function automatic logic [BS-1:0] rnd_line();
    logic [BS-1:0] r;
    for (int i = 0; i < BS / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] stb;   // {wr2, rd2, wr1, rd1}
    logic       ack;
    logic       req;
    logic       we;
    int         port;
    logic [1:0] fv;    // {port2, port1}
    logic [1:0] busy;  // {port2, port1}
  } vec_t;

  function automatic vec_t mk(input logic [3:0] stb, input logic ack, input logic req,
                              input logic we, input int port, input logic [1:0] fv,
                              input logic [1:0] busy);
    vec_t v;
    v.stb = stb; v.ack = ack; v.req = req; v.we = we; v.port = port; v.fv = fv; v.busy = busy;
    return v;
  endfunction

  localparam logic [TB-1:0] T1 = 24'h00ABCD, T2 = 24'h000222;
  localparam logic [IB-1:0] I1 = 7'h05, I2 = 7'h12;
  localparam logic [AB-1:0] A1 = 31'h0055E685, A2 = 31'h00011112;
  logic [BS-1:0] wb1, wb2, rd_a5;

  // ---------------- reference model ----------------
  bit            m_v [4];  // slots: 0 WR1, 1 WR2, 2 RD1, 3 RD2
  logic [TB-1:0] m_tag [4];
  logic [IB-1:0] m_idx [4];
  logic [BS-1:0] m_dat [4];
  bit            m_active, m_fv [2], m_ovf [2];
  int            m_cur, m_last, m_next_ok, m_cyc;
  logic [BS-1:0] m_fd [2];
  logic [TB-1:0] m_ft [2];
  logic [IB-1:0] m_fi [2];

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_v[s] = 0; m_tag[s] = '0; m_idx[s] = '0; m_dat[s] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      m_fv[p] = 0; m_ovf[p] = 0; m_fd[p] = '0; m_ft[p] = '0; m_fi[p] = '0;
    end
    m_active = 0; m_cur = 0; m_last = 2; m_next_ok = 0; m_cyc = 0;
  endtask

  task automatic model_edge();
    bit stb [4];
    int base, port, p;
    bit a, b;
    stb[0] = (memory_write_1 === 1'b1); stb[1] = (memory_write_2 === 1'b1);
    stb[2] = (memory_read_1 === 1'b1);  stb[3] = (memory_read_2 === 1'b1);
    for (int i = 0; i < 2; i++) begin m_fv[i] = 0; m_ovf[i] = 0; end
    if (m_active) begin
      if (mem_ack === 1'b1) begin
        m_v[m_cur] = 0;
        m_active   = 0;
        if (m_cur >= 2) begin
          p = m_cur - 2;
          m_fv[p] = 1; m_fd[p] = mem_rdata; m_ft[p] = m_tag[m_cur]; m_fi[p] = m_idx[m_cur];
          m_next_ok = m_cyc + 2;
        end else begin
          m_next_ok = m_cyc + 1;
        end
      end
    end else if (m_cyc >= m_next_ok) begin
      base = (m_v[0] || m_v[1]) ? 0 : 2;
      a = m_v[base]; b = m_v[base+1];
      if (a || b) begin
        port = (a && b) ? ((m_last == 1) ? 2 : 1) : (a ? 1 : 2);
        m_cur = base + port - 1; m_last = port; m_active = 1;
      end
    end
    for (int s = 0; s < 4; s++) begin
      if (stb[s]) begin
        if (m_v[s]) m_ovf[s % 2] = 1;
        else begin
          m_v[s]   = 1;
          m_tag[s] = (s % 2 == 0) ? tag_1_L2 : tag_2_L2;
          m_idx[s] = (s % 2 == 0) ? index_1_L2 : index_2_L2;
          m_dat[s] = (s % 2 == 0) ? wb_data_1 : wb_data_2;
        end
      end
    end
    m_cyc++;
  endtask

  task automatic model_check();
    check("rnd_req", BS'(mem_req), BS'(m_active));
    if (m_active) begin
      check("rnd_we", BS'(mem_we), BS'(m_cur < 2));
      check("rnd_addr", BS'(mem_addr), BS'({m_tag[m_cur], m_idx[m_cur]}));
      check("rnd_wdata", mem_wdata, (m_cur < 2) ? m_dat[m_cur] : '0);
    end
    check("rnd_busy", BS'({busy_2, busy_1}), BS'({m_v[1] | m_v[3], m_v[0] | m_v[2]}));
    check("rnd_ovf", BS'({overflow_2, overflow_1}), BS'({m_ovf[1], m_ovf[0]}));
    check("rnd_fv", BS'({fill_valid_2, fill_valid_1}), BS'({m_fv[1], m_fv[0]}));
    check("rnd_fdata1", fill_data_1, m_fd[0]);
    check("rnd_fdata2", fill_data_2, m_fd[1]);
    check("rnd_ftagidx", BS'({fill_tag_1, fill_index_1, fill_tag_2, fill_index_2}),
          BS'({m_ft[0], m_fi[0], m_ft[1], m_fi[1]}));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t tbl [21];
    int   ovf_cnt, rd1_cnt;
    logic prev_req;

    wb1 = {16{32'h1111_0001}};
    wb2 = {16{32'h2222_0002}};
    rd_a5 = {64{8'hA5}};
    idle_inputs();
    tag_1_L2 = T1; index_1_L2 = I1; tag_2_L2 = T2; index_2_L2 = I2;
    wb_data_1 = wb1; wb_data_2 = wb2; mem_rdata = rd_a5;

    tbl[0]  = mk(4'b0001, 0, 0, 0, 0, 2'b00, 2'b01);
    tbl[1]  = mk(4'b0000, 0, 1, 0, 1, 2'b00, 2'b01);
    tbl[2]  = mk(4'b0000, 1, 0, 0, 0, 2'b01, 2'b00);
    tbl[3]  = mk(4'b0000, 0, 0, 0, 0, 2'b00, 2'b00);
    tbl[4]  = mk(4'b0110, 0, 0, 0, 0, 2'b00, 2'b11);
    tbl[5]  = mk(4'b0000, 0, 1, 1, 1, 2'b00, 2'b11);
    tbl[6]  = mk(4'b0000, 1, 0, 0, 0, 2'b00, 2'b10);
    tbl[7]  = mk(4'b0000, 0, 1, 0, 2, 2'b00, 2'b10);
    tbl[8]  = mk(4'b0000, 1, 0, 0, 0, 2'b10, 2'b00);
    tbl[9]  = mk(4'b0000, 0, 0, 0, 0, 2'b00, 2'b00);
    tbl[10] = mk(4'b1010, 0, 0, 0, 0, 2'b00, 2'b11);
    tbl[11] = mk(4'b0000, 0, 1, 1, 1, 2'b00, 2'b11);
    tbl[12] = mk(4'b0000, 1, 0, 0, 0, 2'b00, 2'b10);
    tbl[13] = mk(4'b0000, 0, 1, 1, 2, 2'b00, 2'b10);
    tbl[14] = mk(4'b0000, 1, 0, 0, 0, 2'b00, 2'b00);
    tbl[15] = mk(4'b1010, 0, 0, 0, 0, 2'b00, 2'b11);
    tbl[16] = mk(4'b0000, 0, 1, 1, 1, 2'b00, 2'b11);
    tbl[17] = mk(4'b0000, 1, 0, 0, 0, 2'b00, 2'b10);
    tbl[18] = mk(4'b0000, 0, 1, 1, 2, 2'b00, 2'b10);
    tbl[19] = mk(4'b0000, 1, 0, 0, 0, 2'b00, 2'b00);
    tbl[20] = mk(4'b0000, 0, 0, 0, 0, 2'b00, 2'b00);

    // Reset state
    repeat (2) tick();
    check_zero("reset");
    @(negedge CLK) RST = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge CLK);
      {memory_write_2, memory_read_2, memory_write_1, memory_read_1} = tbl[i].stb;
      mem_ack = tbl[i].ack;
      tick();
      check($sformatf("tbl%0d_req", i), BS'(mem_req), BS'(tbl[i].req));
      check($sformatf("tbl%0d_busy", i), BS'({busy_2, busy_1}), BS'(tbl[i].busy));
      check($sformatf("tbl%0d_fv", i), BS'({fill_valid_2, fill_valid_1}), BS'(tbl[i].fv));
      check($sformatf("tbl%0d_ovf", i), BS'({overflow_2, overflow_1}), '0);
      if (tbl[i].req) begin
        check($sformatf("tbl%0d_we", i), BS'(mem_we), BS'(tbl[i].we));
        check($sformatf("tbl%0d_addr", i), BS'(mem_addr), BS'((tbl[i].port == 1) ? A1 : A2));
        check($sformatf("tbl%0d_wdata", i), mem_wdata,
              tbl[i].we ? ((tbl[i].port == 1) ? wb1 : wb2) : '0);
      end
      if (tbl[i].fv[0]) begin
        check("fill1_data", fill_data_1, rd_a5);
        check("fill1_tagidx", BS'({fill_tag_1, fill_index_1}), BS'({T1, I1}));
      end
      if (tbl[i].fv[1]) begin
        check("fill2_data", fill_data_2, rd_a5);
        check("fill2_tagidx", BS'({fill_tag_2, fill_index_2}), BS'({T2, I2}));
      end
    end

    // Overflow: RD1 strobed twice while a WR2 sits in ISSUE with ack withheld
    ovf_cnt = 0; rd1_cnt = 0; prev_req = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge CLK);
      idle_inputs();
      memory_write_2 = (c == 0);
      memory_read_1  = (c == 1 || c == 2);
      mem_ack        = (c >= 5) ? mem_req : 1'b0;
      tick();
      if (overflow_1) ovf_cnt++;
      if (mem_req && !prev_req && !mem_we && mem_addr == A1) rd1_cnt++;
      prev_req = mem_req;
      if (c == 2) check("ovf_pulse", BS'({overflow_2, overflow_1}), BS'(2'b01));
    end
    check("ovf_count", BS'(ovf_cnt), BS'(1));
    check("ovf_rd1_issues", BS'(rd1_cnt), BS'(1));
    check("ovf_drained", BS'({busy_2, busy_1, mem_req}), '0);

    // X strobe on write port 2
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      idle_inputs();
      memory_write_2 = 1'bx;
      tick();
      check($sformatf("xstb%0d", c), BS'({busy_2, mem_req}), '0);
    end
    @(negedge CLK) memory_write_2 = 1'b0;

    // Reset mid-transaction
    @(negedge CLK) memory_write_1 = 1'b1;
    tick();
    @(negedge CLK) memory_write_1 = 1'b0;
    tick();
    check("midrst_req_before", BS'(mem_req), BS'(1));
    @(negedge CLK) RST = 1'b0;
    #1;
    check_zero("midrst");
    tick();
    @(negedge CLK) RST = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("postrst%0d", c), BS'({busy_1, busy_2, mem_req}), '0);
    end

    // Randomized run against the model
    @(negedge CLK) RST = 1'b0;
    idle_inputs();
    model_reset();
    tick();
    @(negedge CLK) RST = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      memory_read_1  = ($urandom_range(3) == 0);
      memory_read_2  = ($urandom_range(3) == 0);
      memory_write_1 = ($urandom_range(5) == 0);
      memory_write_2 = ($urandom_range(5) == 0);
      tag_1_L2 = TB'($urandom); tag_2_L2 = TB'($urandom);
      index_1_L2 = IB'($urandom); index_2_L2 = IB'($urandom);
      wb_data_1 = rnd_line(); wb_data_2 = rnd_line();
      mem_ack = ($urandom_range(2) != 0);
      mem_rdata = rnd_line();
      @(posedge CLK);
      model_edge();
      #1;
      model_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l2_mem_arbiter.md
# l2_mem_arbiter

Two-port memory-side arbiter that sits directly downstream of the L2 cache. It captures the L2's per-port miss-read (`memory_read_1/2`) and write-back (`memory_write_1/2`) strobes together with their tag, index and data. It serialises them onto a single main-memory req/ack channel and returns read fill data to the requesting port as a one-cycle pulse. Write-backs always drain before reads, so a read that follows its own victim eviction sees fresh memory contents.

## Interface
Parameters:
- `tag_bits`, 24, tag width of a request.
- `index_bits`, 7, L2 set-index width.
- `block_size`, 512, line width in bits.

Ports (memory address is `{tag, index}`, `tag_bits+index_bits` bits):
- `CLK` in 1: clock.
- `RST` in 1: reset, asynchronous, active-low.
- `memory_read_1`, `memory_read_2` in 1: read-miss strobe per port. Only `1'b1` counts as a request; 0 and X are ignored.
- `memory_write_1`, `memory_write_2` in 1: write-back strobe per port. Only `1'b1` counts as a request.
- `tag_1_L2`, `tag_2_L2` in `tag_bits`: request tag.
- `index_1_L2`, `index_2_L2` in `index_bits`: request index.
- `wb_data_1`, `wb_data_2` in `block_size`: write-back line. Sampled only with the write strobe.
- `busy_1`, `busy_2` out 1: the port has at least one occupied slot.
- `overflow_1`, `overflow_2` out 1: one-cycle pulse when a strobe is dropped because its slot is full.
- `fill_valid_1`, `fill_valid_2` out 1: one-cycle pulse when read data is returned.
- `fill_data_1`, `fill_data_2` out `block_size`: returned line. Held until the next fill on that port.
- `fill_tag_1`, `fill_tag_2` out `tag_bits`: tag of the returned line.
- `fill_index_1`, `fill_index_2` out `index_bits`: index of the returned line.
- `mem_req` out 1: memory request. Held high until acknowledged.
- `mem_we` out 1: 1 = write, 0 = read. Valid while `mem_req` is high.
- `mem_addr` out `tag_bits+index_bits`: request address.
- `mem_wdata` out `block_size`: write data.
- `mem_ack` in 1: memory completion, single-cycle.
- `mem_rdata` in `block_size`: read data. Valid in the cycle `mem_ack` is high for a read.

## Operation
- Four single-entry slots: RD1, WR1, RD2, WR2. Each slot holds valid, tag, index and, for WR slots, data.
- Capture: a strobe at 1 on a rising edge loads its slot.
  - If the slot is already valid, and is not being retired on that same edge, the strobe is dropped and `overflow_n` pulses on the next cycle.
  - A slot being retired on the same edge accepts the new strobe.
  - Read and write strobes on the same port in the same cycle load both slots independently.
- Arbitration happens only in IDLE. Order of selection:
  1. Any valid WR slot beats any valid RD slot.
  2. Within a class, use round-robin by port. The `last_port` pointer starts at 2 (port 1 wins the first tie) and updates to the granted port on every grant.
- FSM states and transitions:
  - IDLE: if any slot is valid, latch the granted slot into the output registers and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `mem_req`=1; `mem_addr`, `mem_we` and `mem_wdata` are stable. When `mem_ack`=1 on an edge, retire the slot.
    - Write: go to IDLE.
    - Read: capture `mem_rdata` into `fill_data_n` with tag and index, then go to RESP.
  - RESP: `fill_valid_n`=1 for the originating port, then go to IDLE.
- `mem_ack` while in IDLE or RESP is ignored.
- `mem_wdata` is 0 for reads.
- `busy_n` = OR of the port's two slot valid bits.

## Timing
- Reset values: all slots invalid; FSM in IDLE; `last_port`=2.
- Reset values of outputs: all outputs 0, including `fill_data`, `fill_tag`, `fill_index`, `mem_addr` and `mem_wdata`.
- Reset asserted mid-transaction forces all of the above at once: `mem_req` drops without waiting for ack, and pending requests are discarded.
- Latency:
  - Strobe sampled at edge E → slot valid after E.
  - Grant at E+1 → `mem_req` high after E+1.
  - `mem_ack` sampled at edge A → `mem_req` low after A.
  - Read: `fill_valid` high during the cycle after A.
  - Next grant no earlier than A+1 for a write, A+2 for a read.
- Minimum read turnaround with `mem_ack` at the first opportunity: strobe edge 0 → fill_valid in cycle 3.
- No starvation: a pending write waits at most one transaction per competing slot.
- A pending read waits only while writes are pending.

## Test plan
- Single read: `memory_read_1`=1, tag=0x00ABCD, index=0x05 at edge 0. Required: `mem_req`=1, `mem_we`=0, `mem_addr`=0x0055E685 after edge 1. Drive ack with `mem_rdata`=512'hA5… at edge 2. Required: `fill_valid_1`=1 in cycle 3 with that data, tag 0x00ABCD, index 0x05, and `busy_1`=0 after edge 2.
- Write priority: `memory_read_2` and `memory_write_1` strobed on the same edge. Required: write (port 1, `mem_we`=1) issues first; read for port 2 issues only after its ack.
- Round-robin: WR1 and WR2 pending together, twice in succession. Required grant order 1, 2, then 1, 2.
- Overflow: `memory_read_1` strobed on two consecutive edges while stalled in ISSUE (ack withheld). Required: `overflow_1` pulses once; only one RD1 transaction is issued.
- X strobe: `memory_write_2`=X for 5 cycles. Required: no capture, `busy_2`=0, `mem_req`=0.
- Reset mid-op: RST low while `mem_req`=1. Required: all outputs 0 at once; after release, no request is reissued.
